// File: rtl/lsu_axil.sv
// lsu_axil: single-outstanding load/store unit from the execute stage to an
// AXI4-Lite data-memory port.
//   request  : i_req_valid/o_req_ready, i_req_we, i_req_width (funct3),
//              i_req_addr, i_req_wdata
//   response : o_rsp_valid/i_rsp_ready, o_rsp_rdata (extended), o_rsp_err
//   AXI-Lite : AR/R, AW/W/B channels, o_prot tied 3'b000
// Every bus and response output comes straight from a flop.
// Build option: LSU_MISALIGN_TRAP_EN - misaligned accesses return err 10
// without bus traffic; when undefined the offset is forced down to the
// access size and the access proceeds.
module lsu_axil #(
  parameter int  XLEN = 32,
  localparam int STRB = XLEN / 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_we,
  input  logic [2:0]      i_req_width,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_rdata,
  output logic [1:0]      o_rsp_err,
  output logic [2:0]      o_prot,
  output logic            o_arvalid,
  input  logic            i_arready,
  output logic [XLEN-1:0] o_araddr,
  input  logic            i_rvalid,
  output logic            o_rready,
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_rresp,
  output logic            o_awvalid,
  input  logic            i_awready,
  output logic [XLEN-1:0] o_awaddr,
  output logic            o_wvalid,
  input  logic            i_wready,
  output logic [XLEN-1:0] o_wdata,
  output logic [STRB-1:0] o_wstrb,
  input  logic            i_bvalid,
  output logic            o_bready,
  input  logic [1:0]      i_bresp
);
  localparam int OFFW = $clog2(STRB);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, RSP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      width_q, width_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [STRB-1:0] wstrb_q, wstrb_d;
  logic [1:0]      err_q, err_d;
  logic            req_rdy_q, req_rdy_d, rsp_vld_q, rsp_vld_d;
  logic            arv_q, arv_d, rrdy_q, rrdy_d;
  logic            awv_q, awv_d, wv_q, wv_d, brdy_q, brdy_d;

  // request decode: byte offset, size-1 mask, legality
  logic [OFFW-1:0] req_off, req_lmask, req_off_al;
  logic            req_illegal;
  assign req_off     = i_req_addr[OFFW-1:0];
  assign req_lmask   = OFFW'((4'd1 << i_req_width[1:0]) - 4'd1);
  assign req_off_al  = req_off & ~req_lmask;
  assign req_illegal = (i_req_width == 3'b111) ||
                       ((XLEN == 32) && (i_req_width == 3'b011 || i_req_width == 3'b110));
`ifdef LSU_MISALIGN_TRAP_EN
  logic req_mis;
  assign req_mis = |(req_off & req_lmask);
`endif

  // load data: shift the addressed lane down, then sign/zero extend
  logic [XLEN-1:0] rsh, rext;
  assign rsh = i_rdata >> {off_q, 3'b000};
  always_comb begin
    case (width_q)
      3'b000:  rext = XLEN'($signed(rsh << (XLEN-8))  >>> (XLEN-8));
      3'b001:  rext = XLEN'($signed(rsh << (XLEN-16)) >>> (XLEN-16));
      3'b010:  rext = XLEN'($signed(rsh << (XLEN-32)) >>> (XLEN-32));
      3'b100:  rext = rsh & ({XLEN{1'b1}} >> (XLEN-8));
      3'b101:  rext = rsh & ({XLEN{1'b1}} >> (XLEN-16));
      3'b110:  rext = rsh & ({XLEN{1'b1}} >> (XLEN-32));
      default: rext = rsh;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    off_d     = off_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    rsp_vld_d = rsp_vld_q;
    arv_d     = arv_q;
    rrdy_d    = rrdy_q;
    awv_d     = awv_q;
    wv_d      = wv_q;
    brdy_d    = brdy_q;
    case (state_q)
      IDLE: if (i_req_valid && req_rdy_q) begin
        width_d = i_req_width;
        off_d   = req_off_al;
        addr_d  = {i_req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
        rdata_d = '0;
        err_d   = 2'b00;
        if (req_illegal) begin
          err_d     = 2'b11;
          rsp_vld_d = 1'b1;
          state_d   = RSP;
`ifdef LSU_MISALIGN_TRAP_EN
        end else if (req_mis) begin
          err_d     = 2'b10;
          rsp_vld_d = 1'b1;
          state_d   = RSP;
`endif
        end else if (i_req_we) begin
          wdata_d = i_req_wdata << {req_off_al, 3'b000};
          wstrb_d = STRB'(((16'd1 << (5'd1 << i_req_width[1:0])) - 16'd1) << req_off_al);
          awv_d   = 1'b1;
          wv_d    = 1'b1;
          state_d = WRITE;
        end else begin
          arv_d   = 1'b1;
          state_d = RADDR;
        end
      end
      RADDR: if (i_arready) begin
        arv_d   = 1'b0;
        rrdy_d  = 1'b1;
        state_d = RDATA;
      end
      RDATA: if (i_rvalid) begin
        rrdy_d    = 1'b0;
        rsp_vld_d = 1'b1;
        err_d     = (i_rresp != 2'b00) ? 2'b01 : 2'b00;
        rdata_d   = (i_rresp != 2'b00) ? '0 : rext;
        state_d   = RSP;
      end
      WRITE: begin
        // AW and W retire independently; move on once both have gone
        awv_d = awv_q & ~i_awready;
        wv_d  = wv_q & ~i_wready;
        if (!awv_d && !wv_d) begin
          brdy_d  = 1'b1;
          state_d = WRESP;
        end
      end
      WRESP: if (i_bvalid) begin
        brdy_d    = 1'b0;
        rsp_vld_d = 1'b1;
        err_d     = (i_bresp != 2'b00) ? 2'b01 : 2'b00;
        rdata_d   = '0;
        state_d   = RSP;
      end
      RSP: if (i_rsp_ready) begin
        rsp_vld_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      width_q   <= '0;
      off_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= '0;
      req_rdy_q <= 1'b0;
      rsp_vld_q <= 1'b0;
      arv_q     <= 1'b0;
      rrdy_q    <= 1'b0;
      awv_q     <= 1'b0;
      wv_q      <= 1'b0;
      brdy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      off_q     <= off_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      req_rdy_q <= req_rdy_d;
      rsp_vld_q <= rsp_vld_d;
      arv_q     <= arv_d;
      rrdy_q    <= rrdy_d;
      awv_q     <= awv_d;
      wv_q      <= wv_d;
      brdy_q    <= brdy_d;
    end
  end

  assign o_req_ready = req_rdy_q;
  assign o_rsp_valid = rsp_vld_q;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;
  assign o_prot      = 3'b000;
  assign o_arvalid   = arv_q;
  assign o_araddr    = addr_q;
  assign o_rready    = rrdy_q;
  assign o_awvalid   = awv_q;
  assign o_awaddr    = addr_q;
  assign o_wvalid    = wv_q;
  assign o_wdata     = wdata_q;
  assign o_wstrb     = wstrb_q;
  assign o_bready    = brdy_q;

endmodule

// File: tb/tb_lsu_axil.sv
// Scoreboarded bench for lsu_axil (XLEN=32): stimulus pushes expected bus
// payloads and responses; negedge monitors pop and compare on handshakes.
module tb_lsu_axil;
  localparam int XLEN = 32;
  localparam int STRB = 4;

  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  logic i_req_valid, o_req_ready, i_req_we;
  logic [2:0] i_req_width;
  logic [31:0] i_req_addr, i_req_wdata;
  logic o_rsp_valid, i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic [1:0] o_rsp_err;
  logic [2:0] o_prot;
  logic o_arvalid, i_arready, i_rvalid, o_rready;
  logic [31:0] o_araddr, i_rdata;
  logic [1:0] i_rresp;
  logic o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready;
  logic [31:0] o_awaddr, o_wdata;
  logic [3:0] o_wstrb;
  logic [1:0] i_bresp;

  lsu_axil #(.XLEN(XLEN)) dut (
    .clk(clk), .rstn(rstn),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_width(i_req_width), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err), .o_prot(o_prot),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp)
  );

  typedef struct { logic [31:0] rdata; logic [1:0] err; } rsp_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } w_t;
  typedef struct { logic [31:0] rdata; logic [1:0] resp; } rplan_t;

  rsp_t        exp_rsp[$];
  logic [31:0] exp_ar[$], exp_aw[$];
  w_t          exp_w[$];
  rplan_t      rd_plan[$];
  logic [1:0]  b_plan[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit fast = 1'b1, hold_b = 1'b0;
  int aw_block = 0, rsp_block = 0, b_cnt = 0;
  int acc_cyc = 0, last_lat = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic miss(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: no expectation queued / bound expired (t=%0t)", nm, $time);
  endtask

  // AXI slave + response consumer; acts at posedge+1 on handshakes seen at negedge
  bit ar_hs, r_hs, aw_hs, w_hs, b_hs, rd_pend, aw_done, w_done, b_pend;
  rplan_t cur_r;
  logic [1:0] cur_b;
  initial begin
    i_req_valid = 0; i_req_we = 0; i_req_width = 0; i_req_addr = 0; i_req_wdata = 0;
    i_rsp_ready = 0; i_arready = 0; i_rvalid = 0; i_rdata = 0; i_rresp = 0;
    i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0;
    rd_pend = 0; aw_done = 0; w_done = 0; b_pend = 0;
    forever begin
      @(negedge clk);
      ar_hs = o_arvalid && i_arready;
      r_hs  = i_rvalid && o_rready;
      aw_hs = o_awvalid && i_awready;
      w_hs  = o_wvalid && i_wready;
      b_hs  = i_bvalid && o_bready;
      @(posedge clk); #1;
      if (!rstn) begin
        i_arready = 0; i_rvalid = 0; i_awready = 0; i_wready = 0; i_bvalid = 0;
        i_rsp_ready = 0; rd_pend = 0; aw_done = 0; w_done = 0; b_pend = 0;
        continue;
      end
      if (r_hs) begin i_rvalid = 0; rd_pend = 0; end
      if (ar_hs) begin
        rd_pend = 1;
        if (rd_plan.size() > 0) cur_r = rd_plan.pop_front();
        else begin cur_r.rdata = 0; cur_r.resp = 0; end
      end
      if (rd_pend && !i_rvalid && (fast || $urandom_range(1) == 1)) begin
        i_rvalid = 1; i_rdata = cur_r.rdata; i_rresp = cur_r.resp;
      end
      if (b_hs) begin i_bvalid = 0; b_pend = 0; b_cnt++; end
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      if (aw_done && w_done && !b_pend) begin
        b_pend = 1; aw_done = 0; w_done = 0;
        cur_b = (b_plan.size() > 0) ? b_plan.pop_front() : 2'b00;
      end
      if (b_pend && !i_bvalid && !hold_b && (fast || $urandom_range(1) == 1)) begin
        i_bvalid = 1; i_bresp = cur_b;
      end
      i_arready = fast || ($urandom_range(1) == 1);
      if (o_awvalid && aw_block > 0) begin aw_block--; i_awready = 0; end
      else i_awready = fast || ($urandom_range(1) == 1);
      i_wready = fast || ($urandom_range(1) == 1);
      if (o_rsp_valid && rsp_block > 0) begin rsp_block--; i_rsp_ready = 0; end
      else i_rsp_ready = fast || ($urandom_range(1) == 1);
    end
  end

  // monitors: handshake compares and valid-hold stability
  bit p_rst, p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_rv, p_rr;
  logic [31:0] p_araddr, p_awaddr, p_wd, p_rd;
  logic [3:0] p_ws;
  logic [1:0] p_err;
  initial begin
    p_rst = 0;
    forever begin
      @(negedge clk);
      if (rstn && p_rst) begin
        if (p_arv && !p_arr) chk("ar_hold", {o_arvalid, o_araddr}, {1'b1, p_araddr});
        if (p_awv && !p_awr) chk("aw_hold", {o_awvalid, o_awaddr}, {1'b1, p_awaddr});
        if (p_wv && !p_wr) chk("w_hold", {o_wvalid, o_wstrb, o_wdata}, {1'b1, p_ws, p_wd});
        if (p_rv && !p_rr) chk("rsp_hold", {o_rsp_valid, o_rsp_err, o_rsp_rdata}, {1'b1, p_err, p_rd});
      end
      if (rstn) begin
        if (o_rsp_valid && !p_rv) last_lat = cyc - acc_cyc;
        if (o_arvalid && i_arready) begin
          if (exp_ar.size() == 0) miss("unexpected_ar");
          else chk("araddr", o_araddr, exp_ar.pop_front());
        end
        if (o_awvalid && i_awready) begin
          if (exp_aw.size() == 0) miss("unexpected_aw");
          else chk("awaddr", o_awaddr, exp_aw.pop_front());
        end
        if (o_wvalid && i_wready) begin
          if (exp_w.size() == 0) miss("unexpected_w");
          else begin
            w_t e;
            e = exp_w.pop_front();
            chk("wdata", o_wdata, e.data);
            chk("wstrb", o_wstrb, e.strb);
          end
        end
        if (o_rsp_valid && i_rsp_ready) begin
          if (exp_rsp.size() == 0) miss("unexpected_rsp");
          else begin
            rsp_t e;
            e = exp_rsp.pop_front();
            chk("rsp_err", o_rsp_err, e.err);
            chk("rsp_rdata", o_rsp_rdata, e.rdata);
          end
        end
      end
      p_rst = rstn; p_arv = o_arvalid; p_arr = i_arready; p_araddr = o_araddr;
      p_awv = o_awvalid; p_awr = i_awready; p_awaddr = o_awaddr;
      p_wv = o_wvalid; p_wr = i_wready; p_wd = o_wdata; p_ws = o_wstrb;
      p_rv = o_rsp_valid; p_rr = i_rsp_ready; p_rd = o_rsp_rdata; p_err = o_rsp_err;
    end
  end

  // reference model + request driver
  task automatic issue(input bit we, input logic [2:0] w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input logic [1:0] rr, input logic [1:0] br);
    int n, off, t;
    bit sgn, ill, mis;
    longint unsigned v, m;
    rsp_t e;
    w_t ew;
    rplan_t p;
    n   = 1 << w[1:0];
    sgn = !w[2];
    off = a % STRB;
    ill = (w == 3'd3) || (w == 3'd6) || (w == 3'd7);
    mis = (off % n) != 0;
    e.rdata = 0;
    e.err = 0;
    if (ill) e.err = 2'b11;
`ifdef LSU_MISALIGN_TRAP_EN
    else if (mis) e.err = 2'b10;
`endif
    else begin
      off = off - (off % n);
      if (we) begin
        exp_aw.push_back(a - (a % STRB));
        ew.data = 32'(wd << (8 * off));
        ew.strb = 4'(((1 << n) - 1) << off);
        exp_w.push_back(ew);
        b_plan.push_back(br);
        e.err = (br != 0) ? 2'b01 : 2'b00;
      end else begin
        exp_ar.push_back(a - (a % STRB));
        p.rdata = rd; p.resp = rr;
        rd_plan.push_back(p);
        v = 64'(rd) >> (8 * off);
        m = (64'd1 << (8 * n)) - 1;
        v = v & m;
        if (sgn && v[8*n-1]) v = v | ~m;
        if (rr != 0) e.err = 2'b01;
        else e.rdata = v[31:0];
      end
    end
    exp_rsp.push_back(e);
    @(posedge clk); #1;
    i_req_valid = 1; i_req_we = we; i_req_width = w; i_req_addr = a; i_req_wdata = wd;
    t = 0;
    forever begin
      @(negedge clk);
      if (o_req_ready) break;
      if (++t > 500) begin miss("req_accept_timeout"); break; end
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    i_req_valid = 0; i_req_addr = $urandom; i_req_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_rsp.size() != 0) begin
      @(negedge clk);
      if (++t > 1000) begin miss("rsp_timeout"); exp_rsp.delete(); break; end
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_req_ready"}, o_req_ready, 0);
    chk({nm, "_valids"}, {o_rsp_valid, o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready}, 6'b0);
    chk({nm, "_rdata"}, o_rsp_rdata, 0);
    chk({nm, "_err"}, o_rsp_err, 0);
    chk({nm, "_wstrb"}, o_wstrb, 0);
  endtask

  initial begin
    int bc0, t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("por");
    chk("prot", o_prot, 3'b000);
    @(posedge clk); #1 rstn = 1;
    @(posedge clk); @(negedge clk);
    chk("ready_after_reset", o_req_ready, 1);

    fast = 1;
    issue(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0); wait_idle();
    chk("lw_latency", last_lat, 3);
    issue(0, 3'b000, 32'h103, 0, 32'h80AABBCC, 0, 0);
    issue(0, 3'b100, 32'h103, 0, 32'h80AABBCC, 0, 0); wait_idle();
    aw_block = 3; bc0 = b_cnt;
    issue(1, 3'b001, 32'h102, 32'h1234, 0, 0, 0); wait_idle();
    chk("sh_b_count", b_cnt - bc0, 1);
    issue(1, 3'b010, 32'h104, 32'hA5A55A5A, 0, 0, 0); wait_idle();
    chk("sw_latency", last_lat, 3);
    issue(0, 3'b010, 32'h101, 0, 32'h11223344, 0, 0); wait_idle();
    rsp_block = 5;
    issue(0, 3'b001, 32'h102, 0, 32'hFFFF0000, 2'b10, 0); wait_idle();
    issue(0, 3'b011, 32'h108, 0, 32'h0, 0, 0);
    issue(1, 3'b111, 32'h10C, 32'h55, 0, 0, 0);
    issue(1, 3'b000, 32'h105, 32'hAB, 0, 0, 2'b01); wait_idle();

    // reset while waiting for B
    hold_b = 1;
    issue(1, 3'b010, 32'h200, 32'hCAFEF00D, 0, 0, 0);
    t = 0;
    while (!o_bready) begin
      @(negedge clk);
      if (++t > 200) begin miss("wresp_timeout"); break; end
    end
    @(posedge clk); #1 rstn = 0;
    exp_rsp.delete(); b_plan.delete();
    @(posedge clk); @(negedge clk);
    chk_reset("mid");
    @(posedge clk); #1 rstn = 1; hold_b = 0;
    @(posedge clk); @(negedge clk);
    chk("ready_after_abort", o_req_ready, 1);
    issue(0, 3'b010, 32'h300, 0, 32'h13579BDF, 0, 0); wait_idle();

    fast = 0;
    for (int i = 0; i < 250; i++) begin
      logic [1:0] rr, br;
      rr = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
      br = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
      if ($urandom_range(7) == 0) rsp_block = $urandom_range(4);
      issue(1'($urandom_range(1)), 3'($urandom_range(7)), $urandom, $urandom, $urandom, rr, br);
    end
    wait_idle();
    repeat (5) @(negedge clk);
    chk("left_ar", exp_ar.size(), 0);
    chk("left_aw", exp_aw.size(), 0);
    chk("left_w", exp_w.size(), 0);
    chk("left_rplan", rd_plan.size(), 0);
    chk("left_bplan", b_plan.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lsu_axil.md
# lsu_axil

Parametrised load/store unit bridging the execute stage to the data-memory AXI4-Lite port. It accepts one load or store request at a time through a valid/ready handshake and issues the matching AR/R or AW/W/B transaction. Sub-word data is lane-shifted with correct sign or zero extension, and strobes are generated from address and width. Completion is returned on a response handshake that carries an error code for the writeback/trap logic.

## Interface
- XLEN, 32, data/address width; 32 or 64 only
- STRB, XLEN/8, write-strobe width (derived, not overridden)
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- i_req_valid  in  1  request valid
- o_req_ready  out  1  unit idle, request accepted when valid&ready
- i_req_we  in  1  1=store, 0=load
- i_req_width  in  3  RV funct3 (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU)
- i_req_addr  in  XLEN  byte address (base+offset already summed)
- i_req_wdata  in  XLEN  store source, data in low bits
- o_rsp_valid  out  1  completion valid
- i_rsp_ready  in  1  completion consumed
- o_rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
- o_rsp_err  out  2  00 ok, 01 bus error, 10 misaligned, 11 illegal width
- o_prot  out  3  AR/AW prot, constant 3'b000
- o_arvalid / i_arready  out/in  1  read-address handshake
- o_araddr  out  XLEN  i_req_addr with low log2(STRB) bits cleared
- i_rvalid / o_rready  in/out  1  read-data handshake
- i_rdata  in  XLEN  read data
- i_rresp  in  2  read response
- o_awvalid / i_awready  out/in  1  write-address handshake
- o_awaddr  out  XLEN  aligned like o_araddr
- o_wvalid / i_wready  out/in  1  write-data handshake
- o_wdata  out  XLEN  lane-shifted store data
- o_wstrb  out  STRB  byte enables
- i_bvalid / o_bready  in/out  1  write-response handshake
- i_bresp  in  2  write response

## Operation
- States: IDLE, RADDR, RDATA, WRITE, WRESP, RSP.
- IDLE: o_req_ready=1. On accept, register we, width, addr, wdata, and offset = addr[log2(STRB)-1:0].
- Illegal width (011, 110 when XLEN=32; 111 always) -> RSP, err 11, no bus traffic.
- Load: RADDR holds o_arvalid until i_arready -> RDATA. o_rready=1 in RDATA. On i_rvalid: rdata>>(8*offset), extended per width (signed B/H/W, zero BU/HU/WU, D raw) -> RSP. i_rresp!=00 -> err 01, rdata 0.
- Store: WRITE asserts o_awvalid and o_wvalid together, dropping each independently once its ready is seen. Both done -> WRESP. o_wdata = wdata<<(8*offset). o_wstrb = ((1<<size)-1)<<offset. o_bready=1 in WRESP. i_bresp!=00 -> err 01.
- RSP: o_rsp_valid held with stable data until i_rsp_ready, then -> IDLE.
- Accesses crossing an STRB boundary are handled as described under Configuration.

## Timing
- Reset: state IDLE. o_req_ready, o_rsp_valid, o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready all 0 while rstn low. o_rsp_rdata 0, o_rsp_err 00, o_wstrb 0.
- All bus and response outputs are registered.
- Load best case: accept cycle 0, o_arvalid cycle 1, o_rready cycle 2 (rvalid seen), o_rsp_valid cycle 3.
- Store best case: accept 0, aw/w valid 1, bvalid seen 2, o_rsp_valid 3.
- AXI rule: a valid, once raised, stays high with stable payload until the corresponding ready.
- Reset mid-transaction aborts to IDLE immediately. The interconnect is reset by the same rstn.
- i_rsp_ready in the same cycle o_rsp_valid rises completes the handshake that cycle; o_req_ready returns the next cycle.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: a misaligned access (offset not a multiple of access size) -> RSP with err 10, no bus traffic.
- LSU_MISALIGN_TRAP_EN undefined: offset is force-aligned down to the access size (low bits masked), the transaction proceeds, and err 10 is never produced.

## Test plan
- LW at 0x100, rdata 0xDEADBEEF, arready/rvalid immediate -> araddr 0x100, rsp at cycle 3, rdata 0xDEADBEEF, err 00.
- LB at 0x103 with rdata 0x80AABBCC -> 0xFFFFFF80; LBU same -> 0x00000080.
- SH at 0x102 with wdata 0x1234 -> awaddr 0x100, wdata 0x12340000, wstrb 4'b1100; awready delayed 3 cycles, wready immediate -> single bready handshake, err 00.
- LW at 0x101 -> with macro: err 10, no arvalid ever. Without macro: araddr 0x100, normal data.
- i_rresp=2'b10 on LH -> rsp err 01, rdata 0; i_rsp_ready held low 5 cycles -> rsp stable throughout.
- rstn low while in WRESP -> all valids 0 next cycle, o_req_ready 1 after release; a fresh LW completes normally.
